// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared widths, entry record and age helper for the ALU reservation station
package rs_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_BITS  = 4;
    localparam int TYPE_BITS = 5;

    typedef struct packed {
        logic                 busy;
        logic [TYPE_BITS-1:0] op_type;
        logic [ROB_BITS-1:0]  rob_id;
        logic [XLEN-1:0]      v1;
        logic [XLEN-1:0]      v2;
        logic                 dep1;
        logic                 dep2;
        logic [ROB_BITS-1:0]  tag1;
        logic [ROB_BITS-1:0]  tag2;
    } rs_entry_t;

    // Distance from the ROB head; the modular wrap makes ids just past the
    // head compare as older than ids that have wrapped around to zero.
    function automatic logic [ROB_BITS-1:0] rs_age(input logic [ROB_BITS-1:0] rob_id,
                                                   input logic [ROB_BITS-1:0] head);
        return rob_id - head;
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// rtl/rs_oldest_select.sv - binary reduction tree picking the smallest-age requester
// Ports:
//   req   : per-entry request bits
//   age   : packed per-entry ages, entry 0 in the LSBs (tie ages to 0 for a lowest-index pick)
//   valid : at least one request
//   idx   : winning entry; on equal age the lower index wins
module rs_oldest_select #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       age,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int LV = $clog2(N);
    localparam int IW = $clog2(N);

    logic          lv_v [LV+1][N];
    logic [W-1:0]  lv_a [LV+1][N];
    logic [IW-1:0] lv_x [LV+1][N];
    logic          take_r;

    always_comb begin
        take_r = 1'b0;
        for (int l = 0; l <= LV; l++) begin
            for (int i = 0; i < N; i++) begin
                lv_v[l][i] = 1'b0;
                lv_a[l][i] = '0;
                lv_x[l][i] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            lv_v[0][i] = req[i];
            lv_a[0][i] = age[i*W +: W];
            lv_x[0][i] = IW'(i);
        end
        // Left child always covers lower indices, so it keeps ties.
        for (int l = 1; l <= LV; l++) begin
            for (int i = 0; i < (N >> l); i++) begin
                take_r = lv_v[l-1][2*i+1] &
                         (!lv_v[l-1][2*i] | (lv_a[l-1][2*i+1] < lv_a[l-1][2*i]));
                lv_v[l][i] = lv_v[l-1][2*i] | lv_v[l-1][2*i+1];
                lv_a[l][i] = take_r ? lv_a[l-1][2*i+1] : lv_a[l-1][2*i];
                lv_x[l][i] = take_r ? lv_x[l-1][2*i+1] : lv_x[l-1][2*i];
            end
        end
        valid = lv_v[LV][0];
        idx   = lv_x[LV][0];
    end

endmodule

// File: rtl/rs_age_queue.sv
// rtl/rs_age_queue.sv - ALU reservation station issuing the oldest ready op relative to the ROB head
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable), flush (ROB clear), rob_head
//   in_*      : decoder insert port; full advises the decoder not to insert next cycle
//   cdb_*     : NCDB packed wakeup channels, channel 0 in the LSBs
//   issue_*   : valid/ready issue port to the ALU
//   count     : occupied entries
module rs_age_queue
    import rs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NCDB  = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic [ROB_BITS-1:0]      rob_head,
    output logic                     full,
    input  logic                     in_valid,
    input  logic [TYPE_BITS-1:0]     in_type,
    input  logic [ROB_BITS-1:0]      in_rob_id,
    input  logic [XLEN-1:0]          in_v1,
    input  logic [XLEN-1:0]          in_v2,
    input  logic                     in_dep1,
    input  logic                     in_dep2,
    input  logic [ROB_BITS-1:0]      in_tag1,
    input  logic [ROB_BITS-1:0]      in_tag2,
    input  logic [NCDB-1:0]          cdb_valid,
    input  logic [NCDB*ROB_BITS-1:0] cdb_tag,
    input  logic [NCDB*XLEN-1:0]     cdb_value,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [TYPE_BITS-1:0]     issue_type,
    output logic [ROB_BITS-1:0]      issue_rob_id,
    output logic [XLEN-1:0]          issue_v1,
    output logic [XLEN-1:0]          issue_v2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    rs_entry_t ent_q [DEPTH];
    rs_entry_t ent_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    // Registered copy of the full advice; gates this cycle's insert.
    logic          full_q, full_d;

    logic [DEPTH-1:0]          ready_vec, free_vec;
    logic [DEPTH*ROB_BITS-1:0] age_vec;
    logic                      sel_valid, alloc_valid;
    logic [IW-1:0]             sel_idx, alloc_idx;
    logic                      insert, fire;
    rs_entry_t                 new_ent;
    logic                      hit1, hit2, wk_hit;
    logic [XLEN-1:0]           val1, val2, wk_val;

    // Lowest channel wins when several broadcast the same tag.
    function automatic logic cdb_match(input  logic [ROB_BITS-1:0] tag,
                                       output logic [XLEN-1:0]     val);
        logic hit;
        hit = 1'b0;
        val = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_tag[k*ROB_BITS +: ROB_BITS] == tag)) begin
                hit = 1'b1;
                val = cdb_value[k*XLEN +: XLEN];
            end
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = ent_q[i].busy & ~ent_q[i].dep1 & ~ent_q[i].dep2;
            free_vec[i]  = ~ent_q[i].busy;
            age_vec[i*ROB_BITS +: ROB_BITS] = rs_age(ent_q[i].rob_id, rob_head);
        end
    end

    rs_oldest_select #(.N(DEPTH), .W(ROB_BITS)) u_issue_sel (
        .req   (ready_vec),
        .age   (age_vec),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    rs_oldest_select #(.N(DEPTH), .W(1)) u_alloc_sel (
        .req   (free_vec),
        .age   ('0),
        .valid (alloc_valid),
        .idx   (alloc_idx)
    );

    always_comb begin
        issue_valid  = sel_valid;
        issue_type   = sel_valid ? ent_q[sel_idx].op_type : '0;
        issue_rob_id = sel_valid ? ent_q[sel_idx].rob_id  : '0;
        issue_v1     = sel_valid ? ent_q[sel_idx].v1      : '0;
        issue_v2     = sel_valid ? ent_q[sel_idx].v2      : '0;
        count        = count_q;
        // Conservative: a same-cycle fire is not credited.
        full = (count_q == CW'(DEPTH)) | ((count_q == CW'(DEPTH - 1)) & in_valid);
    end

    always_comb begin
        insert = rdy_in & ~flush & in_valid & ~full_q & alloc_valid;
        fire   = rdy_in & ~flush & sel_valid & issue_ready;

        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.op_type = in_type;
        new_ent.rob_id  = in_rob_id;
        new_ent.v1      = in_v1;
        new_ent.v2      = in_v2;
        new_ent.dep1    = in_dep1;
        new_ent.dep2    = in_dep2;
        new_ent.tag1    = in_tag1;
        new_ent.tag2    = in_tag2;
        hit1 = cdb_match(in_tag1, val1);
        hit2 = cdb_match(in_tag2, val2);
        if (in_dep1 && hit1) begin
            new_ent.v1   = val1;
            new_ent.dep1 = 1'b0;
        end
        if (in_dep2 && hit2) begin
            new_ent.v2   = val2;
            new_ent.dep2 = 1'b0;
        end

        ent_d   = ent_q;
        count_d = count_q;
        full_d  = full_q;
        wk_hit  = 1'b0;
        wk_val  = '0;
        if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i].busy = 1'b0;
                    ent_d[i].dep1 = 1'b0;
                    ent_d[i].dep2 = 1'b0;
                end
                count_d = '0;
                full_d  = 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_q[i].busy && ent_q[i].dep1) begin
                        wk_hit = cdb_match(ent_q[i].tag1, wk_val);
                        if (wk_hit) begin
                            ent_d[i].v1   = wk_val;
                            ent_d[i].dep1 = 1'b0;
                        end
                    end
                    if (ent_q[i].busy && ent_q[i].dep2) begin
                        wk_hit = cdb_match(ent_q[i].tag2, wk_val);
                        if (wk_hit) begin
                            ent_d[i].v2   = wk_val;
                            ent_d[i].dep2 = 1'b0;
                        end
                    end
                end
                if (fire) begin
                    ent_d[sel_idx].busy = 1'b0;
                end
                // alloc_idx is never the fired slot: that one was busy at cycle start.
                if (insert) begin
                    ent_d[alloc_idx] = new_ent;
                end
                count_d = count_q + CW'(insert) - CW'(fire);
                full_d  = full;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: doc/rs_age_queue.md
# rs_age_queue

Parametrised reservation station for the ALU issue path, sitting between the Decoder and the ALU and snooping all common-data-bus (CDB) channels. It holds up to DEPTH in-flight ALU ops and wakes operands from any of NCDB broadcast channels, including on the insertion cycle. Each cycle it issues the oldest ready op relative to the ROB head, and only while the ALU accepts (ready/valid backpressure). It supersedes the fixed 4-entry, 2-channel, lowest-index-first station.

## Interface
- DEPTH, 8: entry count, power of two, ≥2
- NCDB, 3: number of CDB/wakeup channels
- ROB_BITS, 4: ROB id width
- TYPE_BITS, 5: ALU op-type width
- XLEN, 32: operand width
- clk_in  in  1  system clock; one clock domain
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; low freezes all state
- flush  in  1  ROB clear; empties the queue when rdy_in is high
- rob_head  in  ROB_BITS  ROB id of the oldest uncommitted instruction
- full  out  1  do not insert next cycle
- in_valid  in  1  decoder inserts an op
- in_type  in  TYPE_BITS  op type
- in_rob_id  in  ROB_BITS  destination ROB id
- in_v1 / in_v2  in  XLEN each  operand values (in_v2 also carries imm)
- in_dep1 / in_dep2  in  1 each  operand still pending
- in_tag1 / in_tag2  in  ROB_BITS each  producer ROB id
- cdb_valid  in  NCDB  per-channel broadcast valid
- cdb_tag  in  NCDB*ROB_BITS  packed ROB ids, channel 0 in LSBs
- cdb_value  in  NCDB*XLEN  packed results
- issue_valid  out  1  an entry is ready
- issue_ready  in  1  ALU accepts
- issue_type  out  TYPE_BITS  op type of the issued entry
- issue_rob_id  out  ROB_BITS  ROB id of the issued entry
- issue_v1 / issue_v2  out  XLEN each  operand values of the issued entry
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry state: busy, type, rob_id, v1/v2, dep1/dep2, tag1/tag2.
- Ready entry: busy & !dep1 & !dep2.
- Age of an entry is (rob_id − rob_head) mod 2^ROB_BITS; smaller is older. issue_* reflects the oldest ready entry; on equal age, the lower index wins.
- issue_* outputs are combinational from registered state. Wakeups arriving in the current cycle do not make an entry issuable until the next cycle.
- fire = rdy_in & issue_valid & issue_ready. On fire the selected entry's busy clears at the clock edge.
- Insert = rdy_in & in_valid & !full_q, where full_q is full as computed for that cycle.
  - The op is written into the lowest-index non-busy entry as of the start of the cycle.
  - An entry freed by fire in the same cycle is not reusable until the next cycle.
  - in_valid while full is ignored.
- Insertion bypass: for each operand with in_depX=1, if any cdb_valid[k] has cdb_tag[k]==in_tagX, store cdb_value[k] and clear depX.
- Resident wakeup: every busy entry with depX and a tag match on any channel captures the value and clears depX.
- Multiple channels matching the same tag is a producer bug. The lowest channel index wins, deterministically.
- full = (count==DEPTH) | (count==DEPTH−1 & in_valid). This is conservative: it ignores a same-cycle fire.
- count update: count_next = count + insert − fire.
- flush & rdy_in: clear all busy and dep bits and zero count; in the same cycle, insert, fire and wakeup are suppressed. issue_valid still shows the pre-flush selection combinationally, but the ALU's own flush handling discards it.
- rdy_in low: no state change; issue_valid may stay high, but fire cannot occur.

## Timing
- Reset (rst_in high at an edge): all busy, dep, type, tag and value fields go to 0; count=0. Outputs after reset: issue_valid=0, issue_* =0, full=0 unless in_valid is high with DEPTH==1 (excluded by the DEPTH≥2 rule).
- Reset overrides flush and rdy_in. Reset mid-operation discards all entries.
- Insert-to-issue latency is 1 cycle minimum: an op inserted with no deps (or bypass-cleared) can assert issue_valid the next cycle.
- CDB-to-issue latency is 1 cycle.
- Backpressure: while issue_ready=0 the selection may change as older entries become ready. The ALU samples issue_* only on fire.
- ROB id wrap-around is handled by the modular age computation. rob_head must be valid every cycle.

## Structure
- Shared package (rs_pkg) holds:
  - type/width constants: XLEN, ROB_BITS, TYPE_BITS
  - the entry struct
  - the age function (rob_id − head modulo)
- Sub-module rs_oldest_select: a parametrised binary reduction tree over DEPTH entries. Inputs are ready bits and ages; output is {valid, index}. One instance is used for issue selection. A second, age-less instance (lowest free index) is used for allocation.

## Test plan
- Reset then idle → issue_valid=0, count=0, full=0. Insert {rob 3, v1=5, v2=7, no deps} → next cycle issue_valid=1, issue_rob_id=3, issue_v2=7.
- Head wrap: head=14, entries rob 15, 0, 1 all ready → issue order 15, 0, 1 with issue_ready=1.
- Insert dep1 tag=6 while cdb channel 2 broadcasts tag 6 value 0xDEAD in the same cycle → stored v1=0xDEAD, dep1=0; issued next cycle.
- Fill DEPTH−1 entries with deps pending, assert in_valid → full=1 the same cycle. Extra in_valid is ignored and count stays DEPTH. Wake one entry and fire → count decrements.
- issue_ready=0 for 3 cycles with 2 ready entries → no busy cleared, count unchanged. Raise issue_ready → oldest fires first.
- flush with 5 busy entries plus a simultaneous insert and fire → next cycle count=0, issue_valid=0.
